// File: rtl/regs_pkg.sv
// regs_pkg: shared types and default sizes for the clearing register file
package regs_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;
  localparam int N_DEF = 8;
  localparam int A_DEF = 5;
endpackage

// File: rtl/regs_clr_seq.sv
// regs_clr_seq: post-reset clear sequencer walking cnt over every entry, then raising ready
module regs_clr_seq
  import regs_pkg::*;
#(
  parameter int A = A_DEF
) (
  input  logic         clk,
  input  logic         reset,
  output logic [A-1:0] cnt,
  output logic         clr_we,
  output logic         ready
);
  state_t state, next;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= next;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end
  always_comb next = (state == CLEAR && cnt == '1) ? RUN : state;
  always_comb begin
    clr_we = (state == CLEAR) && !reset;
    ready  = (state == RUN);
  end
endmodule

// File: rtl/regs_sync_clr.sv
// regs_sync_clr: 2**A x N register file, sync reads with write-first bypass, hardware clear after reset
module regs_sync_clr
  import regs_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int A        = A_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         w,
  input  logic [N-1:0] Wdata,
  input  logic [A-1:0] rs,
  input  logic [A-1:0] rd,
  output logic [N-1:0] rs_data,
  output logic [N-1:0] rd_data,
  output logic         ready
);
  logic [N-1:0] mem [2**A];
  logic [A-1:0] cnt, waddr;
  logic [N-1:0] wdat;
  logic         clr_we, user_we, mem_we, zero_s, zero_d;
  regs_clr_seq #(.A(A)) u_seq (
    .clk(clk), .reset(reset), .cnt(cnt), .clr_we(clr_we), .ready(ready)
  );
  always_comb begin
    zero_s  = (ZERO_REG != 0) && rs == '0;
    zero_d  = (ZERO_REG != 0) && rd == '0;
    user_we = ready && w && !zero_d;
    mem_we  = clr_we || user_we;
    waddr   = clr_we ? cnt : rd;
    wdat    = clr_we ? '0 : Wdata;
  end
  // Array has no reset so it can map onto plain sync RAM; the sequencer clears it
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= wdat;
  end
  always_ff @(posedge clk) begin
    if (reset || !ready) begin
      rs_data <= '0;
      rd_data <= '0;
    end else begin
      rs_data <= zero_s ? '0 : (w && rs == rd) ? Wdata : mem[rs];
      rd_data <= zero_d ? '0 : w ? Wdata : mem[rd];
    end
  end
endmodule

// File: tb/tb_regs_sync_clr.sv
// tb_regs_sync_clr: directed vector table plus clear/reset sequences for regs_sync_clr
module tb_regs_sync_clr;
  logic       clk = 0, reset = 1, w = 0, ready;
  logic [7:0] Wdata = 0, rs_data, rd_data;
  logic [4:0] rs = 0, rd = 0;
  int errors = 0, checks = 0;

  regs_sync_clr #(.N(8), .A(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .w(w), .Wdata(Wdata), .rs(rs), .rd(rd),
    .rs_data(rs_data), .rd_data(rd_data), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [7:0] wdata;
    logic [7:0] exp_rs;
    logic [7:0] exp_rd;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_run(input string tag);
    for (int e = 1; e <= 32; e++) begin
      tick();
      chk($sformatf("%s ready edge %0d", tag, e), {7'b0, ready}, (e == 32) ? 8'd1 : 8'd0);
      if (e < 32) begin
        chk($sformatf("%s rs_data edge %0d", tag, e), rs_data, 8'h00);
        chk($sformatf("%s rd_data edge %0d", tag, e), rd_data, 8'h00);
      end
    end
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b1, 5'd1,  5'd0,  8'h03, 8'h00, 8'h03};
    vecs[1]  = '{1'b1, 5'd6,  5'd1,  8'h0B, 8'h03, 8'h0B};
    vecs[2]  = '{1'b1, 5'd9,  5'd9,  8'hA5, 8'hA5, 8'hA5};
    vecs[3]  = '{1'b0, 5'd9,  5'd9,  8'h00, 8'hA5, 8'hA5};
    vecs[4]  = '{1'b1, 5'd0,  5'd0,  8'hFF, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 5'd0,  5'd0,  8'h00, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 5'd6,  5'd1,  8'h00, 8'h03, 8'h0B};
    vecs[7]  = '{1'b1, 5'd20, 5'd6,  8'h5A, 8'h0B, 8'h5A};
    vecs[8]  = '{1'b1, 5'd6,  5'd6,  8'h77, 8'h77, 8'h77};
    vecs[9]  = '{1'b0, 5'd20, 5'd6,  8'h00, 8'h77, 8'h5A};
    vecs[10] = '{1'b1, 5'd31, 5'd20, 8'hC3, 8'h5A, 8'hC3};
    vecs[11] = '{1'b0, 5'd31, 5'd31, 8'h00, 8'hC3, 8'hC3};
    vecs[12] = '{1'b1, 5'd0,  5'd31, 8'h12, 8'hC3, 8'h00};
    vecs[13] = '{1'b1, 5'd5,  5'd0,  8'h80, 8'h00, 8'h80};

    tick();
    tick();
    chk("reset ready", {7'b0, ready}, 8'd0);
    chk("reset rs_data", rs_data, 8'h00);
    chk("reset rd_data", rd_data, 8'h00);

    // user writes to %1 during the whole clear must be ignored
    reset = 0; w = 1; rd = 1; Wdata = 8'h03;
    clear_run("clear1");
    w = 0;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rd = 5'(31 - i);
      tick();
      chk($sformatf("cleared rs %0d", i), rs_data, 8'h00);
      chk($sformatf("cleared rd %0d", 31 - i), rd_data, 8'h00);
    end

    for (int i = 0; i < 14; i++) begin
      w = vecs[i].w; rd = vecs[i].rd; rs = vecs[i].rs; Wdata = vecs[i].wdata;
      tick();
      chk($sformatf("vec %0d rs_data", i), rs_data, vecs[i].exp_rs);
      chk($sformatf("vec %0d rd_data", i), rd_data, vecs[i].exp_rd);
    end

    // reset in RUN, then again mid-clear at cnt=10; %20 held 5A before
    w = 0; reset = 1;
    tick();
    chk("run reset ready", {7'b0, ready}, 8'd0);
    reset = 0;
    for (int e = 0; e < 10; e++) tick();
    chk("midclear ready", {7'b0, ready}, 8'd0);
    reset = 1;
    tick();
    reset = 0;
    clear_run("clear2");
    rs = 5'd20; rd = 5'd31;
    tick();
    chk("post clear %20", rs_data, 8'h00);
    chk("post clear %31", rd_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
